// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: ramps RGB duty thresholds through a 4-entry colour table with per-colour dwell.
module rgb_fade_sequencer #(
  parameter int DUTY_W     = 16,
  parameter int STEP_DIV   = 1024,
  parameter int STEP       = 64,
  parameter int HOLD_TICKS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              next_req,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_idx,
  input  logic [DUTY_W-1:0] cfg_r,
  input  logic [DUTY_W-1:0] cfg_g,
  input  logic [DUTY_W-1:0] cfg_b,
  output logic [DUTY_W-1:0] R_duty,
  output logic [DUTY_W-1:0] G_duty,
  output logic [DUTY_W-1:0] B_duty,
  output logic [1:0]        cur_idx,
  output logic              busy,
  output logic              at_target
);
  localparam int PW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);
  typedef enum logic [1:0] {IDLE, FADE, HOLD} state_t;
  state_t state, state_n;
  logic [PW-1:0] pre;
  logic [HW-1:0] hold, hold_n;
  logic [1:0] idx_n;
  logic [DUTY_W-1:0] tab_r [4];
  logic [DUTY_W-1:0] tab_g [4];
  logic [DUTY_W-1:0] tab_b [4];
  logic [DUTY_W-1:0] t_r, t_g, t_b, s_r, s_g, s_b, r_n, g_n, b_n;
  logic tick;
  // Moves d toward t by at most STEP; the extra bit keeps the difference from wrapping.
  function automatic logic [DUTY_W-1:0] step_to(input logic [DUTY_W-1:0] d, input logic [DUTY_W-1:0] t);
    logic [DUTY_W:0] diff;
    diff = (d < t) ? {1'b0, t} - {1'b0, d} : {1'b0, d} - {1'b0, t};
    if (diff > (DUTY_W+1)'(STEP)) diff = (DUTY_W+1)'(STEP);
    return (d < t) ? DUTY_W'({1'b0, d} + diff) : DUTY_W'({1'b0, d} - diff);
  endfunction
  assign tick = pre == PW'(STEP_DIV - 1);
  assign t_r = tab_r[cur_idx];
  assign t_g = tab_g[cur_idx];
  assign t_b = tab_b[cur_idx];
  assign s_r = step_to(R_duty, t_r);
  assign s_g = step_to(G_duty, t_g);
  assign s_b = step_to(B_duty, t_b);
  assign busy = state != IDLE;
  assign at_target = R_duty == t_r && G_duty == t_g && B_duty == t_b;
  always_comb begin
    state_n = state;
    hold_n = hold;
    idx_n = cur_idx;
    r_n = R_duty;
    g_n = G_duty;
    b_n = B_duty;
    if (state == IDLE) begin
      idx_n = next_req ? cur_idx + 2'd1 : cur_idx;
      state_n = run ? FADE : IDLE;
    end else if (!run || next_req) begin
      state_n = run ? FADE : IDLE;
      hold_n = '0;
      idx_n = next_req ? cur_idx + 2'd1 : cur_idx;
    end else if (tick && state == FADE) begin
      r_n = s_r;
      g_n = s_g;
      b_n = s_b;
      if (s_r == t_r && s_g == t_g && s_b == t_b) begin
        state_n = HOLD;
        hold_n = HW'(HOLD_TICKS);
      end
    end else if (tick) begin
      // A table rewrite during dwell sends us back to ramping instead of counting down.
      state_n = (!at_target || hold == HW'(1)) ? FADE : HOLD;
      hold_n = (!at_target || hold == HW'(1)) ? '0 : hold - HW'(1);
      idx_n = (at_target && hold == HW'(1)) ? cur_idx + 2'd1 : cur_idx;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      pre <= '0;
      hold <= '0;
      cur_idx <= '0;
      R_duty <= '0;
      G_duty <= '0;
      B_duty <= '0;
      for (int i = 0; i < 4; i++) begin
        tab_r[i] <= (i == 0 || i == 3) ? '1 : '0;
        tab_g[i] <= (i == 1 || i == 3) ? '1 : '0;
        tab_b[i] <= (i == 2 || i == 3) ? '1 : '0;
      end
    end else begin
      state <= state_n;
      pre <= tick ? '0 : pre + PW'(1);
      hold <= hold_n;
      cur_idx <= idx_n;
      R_duty <= r_n;
      G_duty <= g_n;
      B_duty <= b_n;
      if (cfg_we) begin
        tab_r[cfg_idx] <= cfg_r;
        tab_g[cfg_idx] <= cfg_g;
        tab_b[cfg_idx] <= cfg_b;
      end
    end
  end
endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// tb_rgb_fade_sequencer: directed checks of ramp, dwell, table writes, skip, freeze and reset.
module tb_rgb_fade_sequencer;
  logic clk = 0;
  logic rst, run, next_req, cfg_we;
  logic [1:0] cfg_idx, cur_idx;
  logic [15:0] cfg_r, cfg_g, cfg_b, R_duty, G_duty, B_duty;
  logic busy, at_target;
  int compared = 0, mismatched = 0;
  rgb_fade_sequencer #(.DUTY_W(16), .STEP_DIV(4), .STEP('h4000), .HOLD_TICKS(2)) dut (
    .clk(clk), .rst(rst), .run(run), .next_req(next_req), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_r(cfg_r), .cfg_g(cfg_g), .cfg_b(cfg_b), .R_duty(R_duty), .G_duty(G_duty), .B_duty(B_duty),
    .cur_idx(cur_idx), .busy(busy), .at_target(at_target)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic write(input logic [1:0] i, input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
    cfg_we = 1; cfg_idx = i; cfg_r = r; cfg_g = g; cfg_b = b;
  endtask
  initial begin
    rst = 0; run = 0; next_req = 0; cfg_we = 0; cfg_idx = 0; cfg_r = 0; cfg_g = 0; cfg_b = 0;
    step(3);
    rst = 1;
    check("rst_r", R_duty, 0);
    check("rst_idx", cur_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_at", at_target, 0);
    run = 1;
    step(4); check("t1_r", R_duty, 'h4000); check("t1_busy", busy, 1);
    step(4); check("t2_r", R_duty, 'h8000);
    step(4); check("t3_r", R_duty, 'hC000);
    step(4); check("t4_r", R_duty, 'hFFFF); check("t4_g", G_duty, 0); check("t4_b", B_duty, 0);
    check("t4_at", at_target, 1);
    step(4); check("hold1_idx", cur_idx, 0);
    step(4); check("hold2_idx", cur_idx, 1); check("hold2_r", R_duty, 'hFFFF);
    step(4); check("x1_r", R_duty, 'hBFFF); check("x1_g", G_duty, 'h4000);
    step(4); check("x2_r", R_duty, 'h7FFF); check("x2_g", G_duty, 'h8000);
    step(4); check("x3_r", R_duty, 'h3FFF); check("x3_g", G_duty, 'hC000);
    step(4); check("x4_r", R_duty, 0); check("x4_g", G_duty, 'hFFFF); check("x4_at", at_target, 1);
    // small target reached in one tick
    run = 0; rst = 0;
    step(1);
    rst = 1;
    write(0, 'h0005, 0, 0);
    step(1);
    cfg_we = 0; run = 1;
    step(3); check("s5_r", R_duty, 'h0005); check("s5_at", at_target, 1);
    step(4); check("s5_h1_idx", cur_idx, 0);
    step(4); check("s5_h2_idx", cur_idx, 1);
    // table rewrites during fade and on a tick edge
    step(4); check("w0_r", R_duty, 0); check("w0_g", G_duty, 'h4000);
    step(4); check("w1_g", G_duty, 'h8000);
    write(1, 'h1000, 0, 0);
    step(1); cfg_we = 0;
    step(3); check("w2_r", R_duty, 'h1000); check("w2_g", G_duty, 'h4000);
    step(3);
    write(1, 0, 0, 'h2000);
    step(1); cfg_we = 0;
    check("w3_r", R_duty, 'h1000); check("w3_g", G_duty, 0); check("w3_b", B_duty, 0);
    check("w3_at", at_target, 0);
    step(4); check("w4_b", B_duty, 0); check("w4_busy", busy, 1); check("w4_idx", cur_idx, 1);
    step(4); check("w5_b", B_duty, 'h2000); check("w5_r", R_duty, 0); check("w5_at", at_target, 1);
    step(8); check("w6_idx", cur_idx, 2);
    step(16); check("w7_b", B_duty, 'hFFFF);
    step(8); check("w8_idx", cur_idx, 3);
    step(16); check("w9_r", R_duty, 'hFFFF); check("w9_g", G_duty, 'hFFFF); check("w9_at", at_target, 1);
    // skip in HOLD wraps 3 -> 0 and re-enters FADE
    next_req = 1;
    step(1); next_req = 0;
    check("nx_idx", cur_idx, 0); check("nx_r", R_duty, 'hFFFF); check("nx_busy", busy, 1);
    step(3); check("nx_fade_r", R_duty, 'hBFFF); check("nx_fade_g", G_duty, 'hBFFF);
    // freeze in IDLE, skip while idle, then resume
    run = 0;
    step(1); check("fz_busy", busy, 0);
    next_req = 1;
    step(1); next_req = 0;
    check("id_idx", cur_idx, 1); check("id_busy", busy, 0);
    step(78); check("fz_r", R_duty, 'hBFFF); check("fz_b", B_duty, 'hBFFF);
    run = 1;
    step(4); check("rs_r", R_duty, 'h7FFF); check("rs_b", B_duty, 'h7FFF); check("rs_idx", cur_idx, 1);
    step(8); check("rs2_b", B_duty, 'h2000); check("rs2_r", R_duty, 0); check("rs2_at", at_target, 1);
    // one-cycle reset in HOLD restores the default table
    rst = 0;
    step(1); rst = 1;
    check("rr_r", R_duty, 0); check("rr_b", B_duty, 0); check("rr_idx", cur_idx, 0); check("rr_busy", busy, 0);
    step(4); check("rr_ramp_r", R_duty, 'h4000); check("rr_ramp_g", G_duty, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/rgb_fade_sequencer.md
Name: rgb_fade_sequencer

Overview:
Controller that sequences the RGB PWM datapath. It holds a 4-entry programmable colour table and ramps three duty-threshold registers toward the current entry at a fixed step rate. It dwells on each colour for a set time, then advances to the next entry. Outputs feed the R/G/B compare inputs of the PWM stage directly, in place of manual up/down button control.

Parameters:
DUTY_W, 16, width of each duty value and table field
STEP_DIV, 1024, clk cycles per step tick (>=2)
STEP, 64, maximum duty change per channel per step tick (>=1)
HOLD_TICKS, 256, step ticks spent in HOLD at each colour (>=1)

Ports:
clk  in  1  system clock (27 MHz)
rst  in  1  synchronous, active-low reset
run  in  1  level; 1 = sequence active, 0 = freeze in IDLE
next_req  in  1  one-cycle pulse; skip to next table entry
cfg_we  in  1  table write strobe
cfg_idx  in  2  table entry to write
cfg_r  in  DUTY_W  red value to write
cfg_g  in  DUTY_W  green value to write
cfg_b  in  DUTY_W  blue value to write
R_duty  out  DUTY_W  red compare threshold
G_duty  out  DUTY_W  green compare threshold
B_duty  out  DUTY_W  blue compare threshold
cur_idx  out  2  current table entry
busy  out  1  1 when state != IDLE
at_target  out  1  1 when all three duties equal table[cur_idx]

Behaviour:
- Everything is sampled on posedge clk. When rst=0 at an edge, all registers take their reset values.
- Reset values:
  - R/G/B_duty = 0, cur_idx = 0, state = IDLE, prescaler = 0, hold counter = 0.
  - Table: 0 = {FFFF,0,0}, 1 = {0,FFFF,0}, 2 = {0,0,FFFF}, 3 = {FFFF,FFFF,FFFF}. Scale to DUTY_W as all-ones / zero.
- Prescaler:
  - Counts 0..STEP_DIV-1 and wraps.
  - tick = (count == STEP_DIV-1), combinational.
  - Free-running in all states. Cleared only by reset.
- Target: table[cur_idx], read combinationally. A table write is therefore visible as the target on the cycle after cfg_we.
- Table write: on cfg_we=1, entry cfg_idx is loaded with {cfg_r, cfg_g, cfg_b}. Writes are accepted in every state.
- States:
  - IDLE:
    - Duties hold their values.
    - next_req advances cur_idx = cur_idx+1 (mod 4) with no ramp.
    - run=1 -> FADE.
  - FADE:
    - On tick, each channel d moves toward target t: if d<t, d = d + min(STEP, t-d); if d>t, d = d - min(STEP, d-t).
    - Compute in DUTY_W+1 bits. No overflow or underflow; a channel never overshoots its target.
    - When at_target=1 at a tick edge (after that tick's update is evaluated), go to HOLD and load hold = HOLD_TICKS. A FADE entered already at target moves to HOLD on its first tick.
  - HOLD:
    - On tick, hold = hold-1.
    - On a tick with hold==1: cur_idx = cur_idx+1 (mod 4), go to FADE.
    - If the target changes through a write, return to FADE on the next tick where at_target=0.
- run=0 in FADE or HOLD -> IDLE on that edge. Duties freeze, hold counter cleared, cur_idx kept.
- next_req in FADE or HOLD: cur_idx+1 (mod 4), go to FADE, hold cleared, duties unchanged on that edge. next_req has priority over the tick-driven transition in the same cycle.
- Simultaneous events:
  - run=0 together with next_req: go to IDLE, and cur_idx still advances.
  - cfg_we to entry cur_idx in the same cycle as a tick: that tick uses the old target.
- at_target and busy are combinational from registers.
- cur_idx wraps 3 -> 0.

Test Plan:
- Reset (STEP_DIV=4, STEP=0x4000, HOLD_TICKS=2), run=1 -> R_duty steps 0x4000, 0x8000, 0xC000, 0xFFFF on consecutive ticks, G/B stay 0. HOLD for 2 ticks, then cur_idx=1. R ramps down 0xBFFF... while G ramps up, and neither overshoots.
- Ramp to target 0x0005 from 0 with STEP=0x4000 -> duty = 0x0005 after one tick, at_target=1, HOLD entered on that edge.
- Mid-FADE, write cfg_idx=cur_idx with {0x1000,0,0} -> the next tick moves R toward 0x1000 (decrements if above). A write in the same cycle as a tick still uses the old target.
- next_req pulse in HOLD at cur_idx=3 -> cur_idx=0, state FADE, duties unchanged that cycle. In IDLE, next_req only increments cur_idx, busy stays 0.
- run dropped mid-FADE -> busy=0 next cycle, duties frozen over 20 ticks. run reasserted -> ramp resumes from the frozen values.
- rst=0 asserted mid-HOLD for one cycle -> all duties 0, cur_idx=0, busy=0, table restored to defaults (read back via ramp on next run).
